// File: rtl/switch_debounce_pkg.sv
// Shared state encodings and default timing constants for the switch debouncer.
// Benches override the defaults with small values to keep runs short.
package switch_debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_WAIT_HIGH = 2'b01,
    S_HIGH      = 2'b10,
    S_WAIT_LOW  = 2'b11
  } state_t;

  localparam int          DEF_CNT_WIDTH  = 16;
  localparam int unsigned DEF_STABLE_CNT = 50000;

endpackage

// File: rtl/switch_debounce_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; reusable for any switch input.
// Nothing sits between the flops so the first stage has a full cycle to resolve.
module sync_2ff (
  input  logic clk,
  input  logic i_arst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge i_arst) begin
    if (i_arst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// Debounces a raw switch: synchronise, require STABLE_CNT steady cycles, then
// emit a registered level plus one-cycle press/release pulses.
//
//   state       | meaning
//   S_LOW       | accepted level 0, idle
//   S_WAIT_HIGH | input went high, counting stable cycles
//   S_HIGH      | accepted level 1, idle
//   S_WAIT_LOW  | input went low, counting stable cycles
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int          CNT_WIDTH  = DEF_CNT_WIDTH,
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic clk,
  input  logic i_arst,
  input  logic i_sw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_WIDTH-1:0] TERM_CNT = CNT_WIDTH'(STABLE_CNT - 1);

  logic                 sw_s;
  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 level_nxt, press_nxt, release_nxt;

  sync_2ff u_sync (
    .clk    (clk),
    .i_arst (i_arst),
    .d      (i_sw),
    .q      (sw_s)
  );

  always_ff @(posedge clk or posedge i_arst) begin
    if (i_arst) begin
      state     <= S_LOW;
      cnt       <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      o_level   <= level_nxt;
      o_press   <= press_nxt;
      o_release <= release_nxt;
    end
  end

  // Pulses default low so they last only for the accepting edge.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = o_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      S_LOW: begin
        if (sw_s) begin
          state_nxt = S_WAIT_HIGH;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!sw_s) begin
          state_nxt = S_LOW;
        end else if (cnt == TERM_CNT) begin
          state_nxt = S_HIGH;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      S_HIGH: begin
        if (!sw_s) begin
          state_nxt = S_WAIT_LOW;
          cnt_nxt   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (sw_s) begin
          state_nxt = S_HIGH;
        end else if (cnt == TERM_CNT) begin
          state_nxt   = S_LOW;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_WIDTH'(1);
        end
      end
      default: state_nxt = S_LOW;
    endcase
  end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Conditions a raw mechanical push-button/slide-switch input for the switch datapath.
- Synchronises the input, rejects bounce with a stable-count state machine, and emits a clean level plus one-cycle press/release pulses.
- o_press drives the i_en of the downstream enabled counter, so each physical press advances the count by exactly one.

Parameters:
- CNT_WIDTH, 16, width of the internal stability counter.
- STABLE_CNT, 16'd50000, number of consecutive synchronised cycles the input must hold before a change is accepted. Must be >=1 and <= 2^CNT_WIDTH.

Ports:
- clk  input  1  system clock, all logic on posedge.
- i_arst  input  1  asynchronous, active-high reset.
- i_sw  input  1  raw switch level, asynchronous to clk, may bounce.
- o_level  output  1  debounced switch level.
- o_press  output  1  one-cycle pulse on an accepted 0->1 transition.
- o_release  output  1  one-cycle pulse on an accepted 1->0 transition.

Behaviour:
- Reset values (i_arst high, asynchronous): sync flops 0; state S_LOW; cnt 0; o_level 0; o_press 0; o_release 0. All outputs are registered.
- Synchroniser: two flops, i_sw -> s1 -> sw_s. No logic is allowed between the flops.
- S_LOW: if sw_s=1, go to S_WAIT_HIGH with cnt<=0. Otherwise stay.
- S_WAIT_HIGH:
  - sw_s=0 -> S_LOW (bounce rejected, no pulse).
  - sw_s=1 and cnt==STABLE_CNT-1 -> S_HIGH; o_level<=1; o_press<=1.
  - Otherwise cnt<=cnt+1.
- S_HIGH: if sw_s=0, go to S_WAIT_LOW with cnt<=0.
- S_WAIT_LOW: mirror of S_WAIT_HIGH.
  - sw_s=1 -> S_HIGH (no pulse).
  - At terminal count -> S_LOW; o_level<=0; o_release<=1.
- Pulse width: o_press/o_release are asserted only on the edge that performs the accepting transition. They clear on the following edge, so the width is exactly one cycle and never two back-to-back.
- Latency: i_sw held high from sampling edge E0 -> o_level and o_press assert at edge E(STABLE_CNT+2). The release path has the same latency.
- Rejection bound: any excursion of sw_s shorter than STABLE_CNT cycles produces no output change.
- Counter width: cnt never exceeds STABLE_CNT-1, so no wrap. STABLE_CNT=1 degenerates to acceptance on the first WAIT cycle.
- Reset mid-count: async reset returns to S_LOW immediately and drops all outputs within the same cycle. A pending pulse is discarded.
- Reset release with i_sw already high: treated as a fresh press. It yields one o_press after full latency.
- o_press and o_release are never high in the same cycle.

Decomposition:
- Shared include/package holds:
  - 2-bit state encodings: S_LOW=2'b00, S_WAIT_HIGH=2'b01, S_HIGH=2'b10, S_WAIT_LOW=2'b11.
  - Default STABLE_CNT/CNT_WIDTH constants, so simulation benches can override with small values.
- One natural sub-module: sync_2ff (1-bit two-flop synchroniser, same clk/i_arst). It is reusable for other async switch inputs.
- FSM and counter stay in switch_debounce.

Test Plan (bench uses STABLE_CNT=4, CNT_WIDTH=3, CLK_PERIOD=10):
1. Reset: assert i_arst with i_sw=0, then release -> o_level=0, o_press=0, o_release=0; all stay 0 for 10 cycles.
2. Clean press: i_sw 0->1 sampled at E0 and held -> o_level=1 and o_press=1 at E6 only; o_press=0 at E7; o_level stays 1.
3. Bounce: i_sw toggles 1,0,1,0 for 3 cycles, then holds 1 -> no pulse during the bounce; exactly one o_press 6 edges after the final stable 1.
4. Glitch: while o_level=1, i_sw drops to 0 for 2 cycles -> o_level stays 1; o_release never asserts.
5. Release: i_sw 1->0 held -> o_level=0 and o_release=1 for exactly one cycle, 6 edges later; o_press stays 0.
6. Reset mid-count: i_sw=1, assert i_arst 3 cycles in (state S_WAIT_HIGH), then release with i_sw still 1 -> outputs go 0 immediately; single o_press 6 edges after reset deassertion.
7. Integration: drive counter_en (WIDTH=3, ULIMIT=3'b110) from o_press; apply 8 clean presses -> o_cnt sequence 1,2,3,4,5,6,0,1.
